// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
// Optional build macro used by the read ports: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One registered read port: address mux, optional write bypass, data/valid flops.
// Build macro: REGFILE_BYPASS_EN (when defined, a same-edge write to the
// addressed register is forwarded to the read result).
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  i_mem,
  input  logic [ADDR_W-1:0]                i_readnum,
  input  logic                             i_read,
`ifdef REGFILE_BYPASS_EN
  input  logic                             i_write,
  input  logic [ADDR_W-1:0]                i_writenum,
  input  logic [DATA_W-1:0]                i_data_in,
`endif
  output logic [DATA_W-1:0]                o_data,
  output logic                             o_valid
);

  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_next_data;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  assign w_rd_data = i_mem[i_readnum];

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  assign w_hit = i_write && (i_writenum == i_readnum);

  // Forward the incoming write word when it targets the register being read.
  always_comb begin
    w_next_data = w_rd_data;
    if (w_hit) w_next_data = i_data_in;
  end
`else
  // Without forwarding the read sees the pre-write register contents.
  always_comb begin
    w_next_data = w_rd_data;
  end
`endif

  // Capture read data on request; valid tracks last cycle's request, data holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_read;
      if (i_read) r_data <= w_next_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : regfile_rdport

// File: rtl/regfile_2r1w.sv
// Register file with one synchronous write port and two registered read ports.
// Build macro: REGFILE_BYPASS_EN enables write-to-read forwarding on both ports.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int NUM_REGS = 2**ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [ADDR_W-1:0]    writenum,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    readnum_a,
  input  logic                 read_a,
  input  logic [ADDR_W-1:0]    readnum_b,
  input  logic                 read_b,
  output logic [DATA_W-1:0]    data_out_a,
  output logic                 valid_a,
  output logic [DATA_W-1:0]    data_out_b,
  output logic                 valid_b,
  output logic [NUM_REGS-1:0]  written
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_mem;
  logic [NUM_REGS-1:0]             r_written;

  // Storage and written bitmap; both cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem     <= '0;
      r_written <= '0;
    end else if (write) begin
      r_mem[writenum]     <= data_in;
      r_written[writenum] <= 1'b1;
    end
  end

  assign written = r_written;

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_mem      (r_mem),
    .i_readnum  (readnum_a),
    .i_read     (read_a),
`ifdef REGFILE_BYPASS_EN
    .i_write    (write),
    .i_writenum (writenum),
    .i_data_in  (data_in),
`endif
    .o_data     (data_out_a),
    .o_valid    (valid_a)
  );

  regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_mem      (r_mem),
    .i_readnum  (readnum_b),
    .i_read     (read_b),
`ifdef REGFILE_BYPASS_EN
    .i_write    (write),
    .i_writenum (writenum),
    .i_data_in  (data_in),
`endif
    .o_data     (data_out_b),
    .o_valid    (valid_b)
  );

endmodule : regfile_2r1w
